// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: walks a 4-input gate through all 16 input vectors and captures its output.
// Optional build macro TT_SWEEP_MAJORITY_EN enables 2-of-3 majority voting of each sampled bit.
module tt_sweep_ctrl #(
  parameter int unsigned  SETTLE_CYCLES = 2,
  parameter logic [15:0]  EXPECTED_TT   = 16'h409B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  gate_in,
  input  logic        gate_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        match
);

  // state  | meaning
  // IDLE   | waiting for start; tt/match hold last result
  // SETTLE | gate_in held steady for SETTLE_CYCLES cycles
  // SAMPLE | capture gate_out (first vote when majority enabled)
  // VOTE2  | second vote sample (majority build only)
  // VOTE3  | third vote sample, majority written to tt (majority build only)
  // DONE   | one-cycle done pulse, match valid
`ifdef TT_SWEEP_MAJORITY_EN
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, VOTE2, VOTE3, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
`endif

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [7:0]  settle_cnt;
  logic        bit_val;
  logic [15:0] tt_upd;

`ifdef TT_SWEEP_MAJORITY_EN
  logic vote_a;
  logic vote_b;

  always_comb begin
    bit_val = (vote_a & vote_b) | (vote_a & gate_out) | (vote_b & gate_out);
  end
`else
  always_comb begin
    bit_val = gate_out;
  end
`endif

  // gate_in doubles as the vector index, so the captured bit lands at tt[gate_in]
  always_comb begin
    tt_upd          = tt;
    tt_upd[gate_in] = bit_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      gate_in    <= 4'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tt         <= 16'h0000;
      match      <= 1'b0;
`ifdef TT_SWEEP_MAJORITY_EN
      vote_a     <= 1'b0;
      vote_b     <= 1'b0;
`endif
    end else if (abort) begin
      state   <= IDLE;
      gate_in <= 4'h0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tt      <= 16'h0000;
      match   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            tt         <= 16'h0000;
            match      <= 1'b0;
            gate_in    <= 4'h0;
            busy       <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == 8'd0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
`ifdef TT_SWEEP_MAJORITY_EN
        SAMPLE: begin
          vote_a <= gate_out;
          state  <= VOTE2;
        end
        VOTE2: begin
          vote_b <= gate_out;
          state  <= VOTE3;
        end
        VOTE3: begin
`else
        SAMPLE: begin
`endif
          tt <= tt_upd;
          if (gate_in == 4'hF) begin
            gate_in <= 4'h0;
            busy    <= 1'b0;
            done    <= 1'b1;
            match   <= (tt_upd == EXPECTED_TT);
            state   <= DONE;
          end else begin
            gate_in    <= gate_in + 4'h1;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench for tt_sweep_ctrl: random gate truth tables, abort, re-start and mid-sweep reset.
module tb_tt_sweep_ctrl;
  localparam int          S   = 2;
  localparam logic [15:0] EXP = 16'h409B;
`ifdef TT_SWEEP_MAJORITY_EN
  localparam int K = 3;
`else
  localparam int K = 1;
`endif
  localparam int VEC   = S + K;
  localparam int TOTAL = 16 * VEC;
  localparam int LAT   = 1 + TOTAL;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [3:0]  gate_in;
  logic        gate_out;
  logic        busy;
  logic        done;
  logic [15:0] tt;
  logic        match;

  tt_sweep_ctrl #(.SETTLE_CYCLES(S), .EXPECTED_TT(EXP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .gate_in(gate_in), .gate_out(gate_out), .busy(busy), .done(done),
    .tt(tt), .match(match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tt;
    logic        match;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          done_count = 0;
  int          accept_cyc = 0;
  bit          sweep_active = 1'b0;
  bit          glitch_en = 1'b0;
  int          glitch_n = -1;
  logic [15:0] gate_fn = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  // gate model: ideal truth-table lookup, optionally flipped on one chosen cycle of the sweep
  always_comb begin
    gate_out = gate_fn[gate_in] ^ (glitch_en && sweep_active && ((cyc - accept_cyc) == glitch_n));
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  int   mon_n;
  exp_t mon_e;
  always @(negedge clk) begin
    mon_n = cyc - accept_cyc;
    if (rst_n && sweep_active && mon_n < TOTAL)
      check("walk_busy_gate_in", {27'd0, busy, gate_in}, {27'd0, 1'b1, 4'(mon_n / VEC)});
    if (done) begin
      done_count++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: done=1 with no sweep outstanding (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("done_tt", {16'd0, tt}, {16'd0, mon_e.tt});
        check("done_match", {31'd0, match}, {31'd0, mon_e.match});
        check("done_latency", cyc - mon_e.acc + 1, LAT);
        check("done_busy_gate_in", {27'd0, busy, gate_in}, 32'd0);
      end
    end
  end

  task automatic do_start(input bit with_abort);
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    @(posedge clk);
    #1;
    start      = 1'b0;
    abort      = 1'b0;
    accept_cyc = cyc;
    sweep_active = !with_abort;
  endtask

  task automatic wait_done(input int budget);
    int c0;
    c0 = done_count;
    for (int i = 0; i < budget && done_count == c0; i++) begin
      @(negedge clk);
      #1;
    end
    check("done_count", done_count - c0, 1);
    sweep_active = 1'b0;
  endtask

  task automatic wait_n(input int n);
    while ((cyc - accept_cyc) < n) @(negedge clk);
  endtask

  task automatic run_sweep(input logic [15:0] fn, input bit glitch, input int gidx);
    int off;
`ifdef TT_SWEEP_MAJORITY_EN
    off = S + int'($urandom_range(0, 2));
`else
    off = int'($urandom_range(0, S - 1));
`endif
    gate_fn   = fn;
    glitch_en = glitch;
    glitch_n  = gidx * VEC + off;
    do_start(1'b0);
    sb.push_back('{fn, (fn == EXP), accept_cyc});
    wait_done(LAT + 20);
    repeat (3) @(negedge clk);
    #1;
    check("hold_tt", {16'd0, tt}, {16'd0, fn});
    check("hold_match", {31'd0, match}, {31'd0, (fn == EXP)});
    check("idle_busy", {31'd0, busy}, 32'd0);
    glitch_en = 1'b0;
  endtask

  initial begin
    int c0;
    logic [15:0] rfn;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {10'd0, busy, done, gate_in, tt}, 32'd0);
    check("reset_match", {31'd0, match}, 32'd0);
    rst_n = 1'b1;

    run_sweep(16'h409B, 1'b0, 0);
    run_sweep(16'h0000, 1'b0, 0);
    run_sweep(16'h409B, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      rfn = 16'($urandom);
      if (i == 2) rfn = EXP;
      run_sweep(rfn, 1'b1, int'($urandom_range(0, 15)));
    end

    // start re-pulsed in cycle 10 of a running sweep
    gate_fn = EXP;
    do_start(1'b0);
    sb.push_back('{EXP, 1'b1, accept_cyc});
    wait_n(9);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(LAT + 20);
    c0 = done_count;
    repeat (5) @(negedge clk);
    #1;
    check("repulse_no_requeue_busy", {31'd0, busy}, 32'd0);
    check("repulse_single_done", done_count - c0, 0);

    // start together with abort in IDLE
    do_start(1'b1);
    @(negedge clk);
    check("start_abort_idle", {27'd0, busy, gate_in}, 32'd0);
    repeat (3) @(negedge clk);
    check("start_abort_idle_later", {27'd0, busy, gate_in}, 32'd0);

    // abort in the first SETTLE cycle of index 7
    gate_fn = 16'($urandom) | 16'h0001;
    do_start(1'b0);
    wait_n(7 * VEC);
    check("pre_abort_gate_in", {28'd0, gate_in}, 32'd7);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    sweep_active = 1'b0;
    check("abort_outputs", {10'd0, busy, done, gate_in, tt}, 32'd0);
    check("abort_match", {31'd0, match}, 32'd0);
    c0 = done_count;
    repeat (100) @(negedge clk);
    #1;
    check("abort_no_done", done_count - c0, 0);

    // reset asserted in cycle 20, released in cycle 23
    gate_fn = EXP;
    do_start(1'b0);
    sb.push_back('{EXP, 1'b1, accept_cyc});
    wait_n(19);
    rst_n = 1'b0;
    sweep_active = 1'b0;
    sb.delete();
    #1;
    check("midreset_outputs", {10'd0, busy, done, gate_in, tt}, 32'd0);
    check("midreset_match", {31'd0, match}, 32'd0);
    wait_n(22);
    rst_n = 1'b1;
    c0 = done_count;
    repeat (60) @(negedge clk);
    #1;
    check("post_reset_no_done", done_count - c0, 0);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    run_sweep(EXP, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 Parameters SHALL be: SETTLE_CYCLES, default 2, number of cycles gate inputs are held before sampling (legal range 1..255); EXPECTED_TT, default 16'h409B, golden 16-bit truth table.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  request a sweep.
- abort  in  1  cancel a sweep.
- gate_in  out  4  drives inputs _3.._0 of the gate under test.
- gate_out  in  1  output of the gate under test.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle completion pulse.
- tt  out  16  captured truth table.
- match  out  1  tt equals EXPECTED_TT.
REQ-003 The block SHALL use one clock, clk; reset SHALL be rst_n, asynchronous and active-low.

Function
REQ-004 The FSM SHALL have the states IDLE, SETTLE, SAMPLE and DONE, plus VOTE2 and VOTE3 when the feature in REQ-018 is compiled in.
REQ-005 In IDLE with start=1 and abort=0, the block SHALL, on that edge, clear tt and match, set the vector index to 0, drive gate_in=4'h0, set busy=1 and enter SETTLE.
REQ-006 SETTLE SHALL hold gate_in constant for exactly SETTLE_CYCLES cycles, then enter SAMPLE.
REQ-007 SAMPLE SHALL last one cycle and write gate_out into tt[index], where index = gate_in interpreted as {_3,_2,_1,_0}.
REQ-008 After SAMPLE with index<15, the block SHALL increment index, update gate_in on the same edge and re-enter SETTLE.
REQ-009 After SAMPLE with index=15, the block SHALL enter DONE and register match = (tt_final == EXPECTED_TT), where tt_final includes the bit just sampled.
REQ-010 DONE SHALL last one cycle with done=1 and busy=0, then enter IDLE; gate_in SHALL return to 4'h0.
REQ-011 Sweep latency SHALL be fixed: with start accepted at edge 0, done is high in cycle 1+16*(SETTLE_CYCLES+1). For the defaults that is cycle 49.
REQ-012 busy SHALL be 1 in every SETTLE and SAMPLE cycle, and 0 in IDLE and DONE.
REQ-013 start SHALL be ignored outside IDLE; an accepted start never queues.
REQ-014 abort=1 in SETTLE or SAMPLE SHALL, on the next edge, force IDLE, busy=0, gate_in=0, tt=0 and match=0, with no done pulse.
REQ-015 abort=1 together with start in IDLE SHALL win: the block stays in IDLE.
REQ-016 tt and match SHALL hold their values after DONE until the next accepted start, abort or reset.

Reset
REQ-017 While rst_n=0, the block SHALL be in state IDLE with gate_in=0, busy=0, done=0, tt=16'h0000, match=0 and index=0. Assertion mid-sweep SHALL take effect immediately; no done pulse SHALL follow release.

Configuration
REQ-018 Macro TT_SWEEP_MAJORITY_EN:
- Defined: SAMPLE, VOTE2 and VOTE3 SHALL sample gate_out on three consecutive cycles and write the 2-of-3 majority into tt[index]. Per-vector time becomes SETTLE_CYCLES+3 cycles, and done falls in cycle 1+16*(SETTLE_CYCLES+3).
- Undefined: single-sample behaviour per REQ-007 and REQ-011 applies; VOTE2 and VOTE3 do not exist.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Ideal 0x409B gate model, defaults, start pulse -> gate_in walks 0..15, each value held 3 cycles; done in cycle 49; tt=16'h409B; match=1.
- gate_out stuck at 0 -> tt=16'h0000, match=0, done in cycle 49.
- abort during SETTLE of index 7 -> next cycle busy=0, gate_in=0, tt=0; no done within 100 cycles.
- start re-pulsed at cycle 10 of a sweep -> ignored; a single done in cycle 49. start+abort together in IDLE -> busy stays 0.
- rst_n low at cycle 20, released at cycle 23 -> all outputs at reset values; a subsequent start gives a full 49-cycle sweep.
- With TT_SWEEP_MAJORITY_EN and a model glitching one of three samples at index 0 -> tt[0] correct, match=1, done in cycle 81.
